systolic_matmul: RTL and testbench
==================================

SYSTOLIC_MATMUL -- requirements
Module: systolic_matmul

Interface
REQ-001 SHALL have parameter N, default 4: systolic array dimension (N×N PEs, N lanes in and out).
REQ-002 SHALL have parameter DW, default 8: element width of weights and inputs.
REQ-003 SHALL have parameter AW, default 2*DW+$clog2(N): output/accumulator width.
REQ-004 SHALL have parameter TMAX, default 16: maximum input vectors per batch.
REQ-005 SHALL have parameter SIGNED, default 1: 1 = two's-complement operands, 0 = unsigned.
REQ-006 SHALL have parameter SAT, default 1: 1 = saturate results to AW bits, 0 = wrap.
REQ-007 CLK  in  1  clock, rising edge.
REQ-008 RSTN  in  1  reset, asynchronous, active-low.
REQ-009 w_valid / w_ready  in / out  1 / 1  weight-row handshake.
REQ-010 w_data  in  N*DW  one weight row; lane c = bits [c*DW +: DW].
REQ-011 in_valid / in_ready  in / out  1 / 1  input-vector handshake.
REQ-012 in_data  in  N*DW  one input vector x[t]; lane c = bits [c*DW +: DW].
REQ-013 in_last  in  1  marks the final input vector of a batch.
REQ-014 out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-015 out_data  out  N*AW  result vector y[t]; lane r = bits [r*AW +: AW].
REQ-016 out_ovf  out  N  per-lane overflow flag for the current out_data.
REQ-017 busy  out  1  high whenever the state is not IDLE.

Function
REQ-018 Computation: y[t][r] = sum over c of W[r][c]*x[t][c], with full-precision accumulation in each PE.
REQ-019 State machine: IDLE, LOAD_W, LOAD_X, COMPUTE, DRAIN.
 - IDLE→LOAD_W on w_valid.
 - IDLE→LOAD_X on in_valid without w_valid (reuse stored weights).
REQ-020 LOAD_W: w_ready=1; accepted row k writes W[k]; after the N-th row go to LOAD_X. Zero-valued rows are legal data.
REQ-021 LOAD_X: in_ready=1; buffer vectors in order. Leave for COMPUTE when a vector with in_last is accepted, or on the TMAX-th accepted vector (implicit last).
REQ-022 COMPUTE: feed buffered vectors skewed so lane c enters c cycles late. Results are captured into the output buffer. COMPUTE lasts exactly Tb+2N-1 cycles, where Tb is the accepted vector count.
REQ-023 DRAIN: present y[0..Tb-1] in order with out_valid=1.
 - A transfer occurs when out_valid and out_ready are both high.
 - out_data and out_ovf SHALL hold stable while out_ready=0.
 - After the Tb-th transfer, go to IDLE.
REQ-024 w_ready and in_ready SHALL be 0 outside LOAD_W and LOAD_X respectively. Handshakes offered in other states are ignored.
REQ-025 Saturation: if SAT=1 and the true sum exceeds the AW range, clamp to max/min and set out_ovf[r]. If SAT=0, truncate to AW bits and set out_ovf[r] anyway.
REQ-026 Weights SHALL persist across batches until the next LOAD_W.
REQ-027 Simultaneous w_valid and in_valid in IDLE: LOAD_W wins.

Reset
REQ-028 While RSTN=0, all outputs SHALL be 0 and the state SHALL be IDLE.
REQ-029 Reset SHALL clear PE pipeline registers and counters. Weight and data buffers need not be cleared; W SHALL be treated as all-zero until first loaded.
REQ-030 Reset asserted mid-batch SHALL abort the batch; no partial results are emitted after release.

Structure
REQ-031 A shared package SHALL hold the state enum and the default N/DW/TMAX constants.
REQ-032 A single sub-module, systolic_pe, SHALL implement a weight-stationary PE: registered pass-through of x, registered partial-sum add of W*x.

Verification
REQ-033 Identity test (N=4, DW=8): load W=I, send x[0]={1,2,3,4} with in_last. Expect y[0]={1,2,3,4}, out_ovf=0, and out_valid first rising exactly 2N-1+1 cycles after COMPUTE entry.
REQ-034 Signed test: W row0={-1,2,-3,4}, x={5,6,7,8}. Expect y[0][0]=-5+12-21+32=18.
REQ-035 Saturation test (DW=8, AW=16 forced): all W=127, all x=127, N=4 gives 64516. Expect SAT=1 → 32767 with out_ovf=4'hF; SAT=0 → wrapped value with out_ovf=4'hF.
REQ-036 Batch-length test: stream TMAX+2 vectors with no in_last. Expect only TMAX accepted, in_ready low afterwards, and TMAX results in order.
REQ-037 Backpressure/reuse test: hold out_ready=0 for 5 cycles mid-DRAIN and expect data stable. Then start a second batch with in_valid only and expect the previous W to be used.
REQ-038 Reset test: pulse RSTN low during COMPUTE. Expect out_valid=0, busy=0, and a clean next batch.

Source files
------------

// File: rtl/systolic_matmul_pkg.sv
// Shared types and default sizing for the weight-stationary systolic matmul.
package systolic_matmul_pkg;

  localparam int N_DEF    = 4;
  localparam int DW_DEF   = 8;
  localparam int TMAX_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_LOAD_X,
    ST_COMPUTE,
    ST_DRAIN
  } state_t;

  // Accumulator wide enough for the exact sum of N products, and at least
  // one bit above AW so overflow against AW is always visible.
  function automatic int acc_width(input int n, input int dw, input int aw);
    int a;
    a = 2 * dw + $clog2(n) + 1;
    return (a > aw + 1) ? a : aw + 1;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// Weight-stationary PE: x moves down one row per cycle, psum moves right.
module systolic_pe
  import systolic_matmul_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int ACCW   = 2 * DW_DEF + 3,
  parameter int SIGNED = 1
) (
  input  logic            CLK,
  input  logic            RSTN,
  input  logic [DW-1:0]   i_w,
  input  logic [DW-1:0]   i_x,
  input  logic [ACCW-1:0] i_psum,
  output logic [DW-1:0]   o_x,
  output logic [ACCW-1:0] o_psum
);

  logic [ACCW-1:0] w_xe;
  logic [ACCW-1:0] w_we;

  // Extend operands to accumulator width; the modular product is exact.
  generate
    if (SIGNED != 0) begin : g_sext
      assign w_xe = {{(ACCW-DW){i_x[DW-1]}}, i_x};
      assign w_we = {{(ACCW-DW){i_w[DW-1]}}, i_w};
    end else begin : g_zext
      assign w_xe = {{(ACCW-DW){1'b0}}, i_x};
      assign w_we = {{(ACCW-DW){1'b0}}, i_w};
    end
  endgenerate

  // Forward x to the next row and add this PE's product to the row's psum.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      o_x    <= '0;
      o_psum <= '0;
    end else begin
      o_x    <= i_x;
      o_psum <= i_psum + w_xe * w_we;
    end
  end

endmodule

// File: rtl/systolic_matmul.sv
// N x N weight-stationary systolic matrix-vector engine with batch buffers.
module systolic_matmul
  import systolic_matmul_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int DW     = DW_DEF,
  parameter int AW     = 2 * DW + $clog2(N),
  parameter int TMAX   = TMAX_DEF,
  parameter int SIGNED = 1,
  parameter int SAT    = 1
) (
  input  logic            CLK,
  input  logic            RSTN,
  input  logic            w_valid,
  output logic            w_ready,
  input  logic [N*DW-1:0] w_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_data,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*AW-1:0] out_data,
  output logic [N-1:0]    out_ovf,
  output logic            busy
);

  localparam int ACCW = acc_width(N, DW, AW);
  localparam int IW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int XW   = $clog2(TMAX + 1);
  localparam int CW   = $clog2(TMAX + 2 * N);
  localparam int RW   = (N > 1) ? $clog2(N) : 1;

  state_t r_state, w_next;

  logic [N-1:0][N-1:0][DW-1:0] r_w;
  logic                        r_wloaded;
  logic [N-1:0][DW-1:0]        r_xbuf [TMAX];
  logic [N-1:0][AW-1:0]        r_obuf [TMAX];
  logic [N-1:0]                r_oovf [TMAX];
  logic [RW-1:0]               r_wrow;
  logic [XW-1:0]               r_xcnt;
  logic [CW-1:0]               r_cnt;
  logic [IW-1:0]               r_rd;

  logic w_w_acc, w_in_acc, w_out_acc;
  logic w_w_done, w_x_done, w_c_done, w_d_done;

  assign w_w_acc   = w_valid && w_ready;
  assign w_in_acc  = in_valid && in_ready;
  assign w_out_acc = out_valid && out_ready;
  assign w_w_done  = w_w_acc && (r_wrow == RW'(N - 1));
  assign w_x_done  = w_in_acc && (in_last || (r_xcnt == XW'(TMAX - 1)));
  assign w_c_done  = (r_cnt == CW'(r_xcnt) + CW'(2 * N - 2));
  assign w_d_done  = w_out_acc && (r_rd == IW'(r_xcnt - 1'b1));

  // State register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; weight load wins over input in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_valid)       w_next = ST_LOAD_W;
        else if (in_valid) w_next = ST_LOAD_X;
      end
      ST_LOAD_W:  if (w_w_done) w_next = ST_LOAD_X;
      ST_LOAD_X:  if (w_x_done) w_next = ST_COMPUTE;
      ST_COMPUTE: if (w_c_done) w_next = ST_DRAIN;
      ST_DRAIN:   if (w_d_done) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state.
  always_comb begin
    w_ready   = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (r_state != ST_IDLE);
    case (r_state)
      ST_LOAD_W: w_ready   = 1'b1;
      ST_LOAD_X: in_ready  = 1'b1;
      ST_DRAIN:  out_valid = 1'b1;
      default:   ;
    endcase
  end

  // Batch counters; a finished weight load marks W as valid.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_wrow    <= '0;
      r_xcnt    <= '0;
      r_cnt     <= '0;
      r_rd      <= '0;
      r_wloaded <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_wrow <= '0;
          r_xcnt <= '0;
          r_cnt  <= '0;
          r_rd   <= '0;
        end
        ST_LOAD_W: if (w_w_acc) begin
          r_wrow    <= r_wrow + 1'b1;
          r_wloaded <= w_w_done;
        end
        ST_LOAD_X:  if (w_in_acc) r_xcnt <= r_xcnt + 1'b1;
        ST_COMPUTE: r_cnt <= r_cnt + 1'b1;
        ST_DRAIN:   if (w_out_acc) r_rd <= r_rd + 1'b1;
        default:    ;
      endcase
    end
  end

  // Weight rows and input vectors land in plain storage (no reset needed).
  always_ff @(posedge CLK) begin
    if (w_w_acc)  r_w[r_wrow] <= w_data;
    if (w_in_acc) r_xbuf[r_xcnt[IW-1:0]] <= in_data;
  end

  // Systolic fabric: x enters row 0 at column c, psum enters column 0 at zero.
  logic [DW-1:0]   w_x  [N+1][N];
  logic [ACCW-1:0] w_ps [N][N+1];
  logic [N-1:0]    w_unused_x;

  generate
    for (genvar c = 0; c < N; c++) begin : g_feed
      logic [CW-1:0] w_j;
      logic          w_fv;
      // Lane c is skewed c cycles so all lanes of x[t] meet along each row.
      assign w_j  = r_cnt - CW'(c);
      assign w_fv = (r_state == ST_COMPUTE) && (r_cnt >= CW'(c)) && (w_j < CW'(r_xcnt));
      assign w_x[0][c] = w_fv ? r_xbuf[w_j[IW-1:0]][c] : '0;
      assign w_unused_x[c] = ^w_x[N][c];
    end

    for (genvar r = 0; r < N; r++) begin : g_row
      assign w_ps[r][0] = '0;
      for (genvar c = 0; c < N; c++) begin : g_col
        systolic_pe #(.DW(DW), .ACCW(ACCW), .SIGNED(SIGNED)) u_pe (
          .CLK    (CLK),
          .RSTN   (RSTN),
          .i_w    (r_wloaded ? r_w[r][c] : {DW{1'b0}}),
          .i_x    (w_x[r][c]),
          .i_psum (w_ps[r][c]),
          .o_x    (w_x[r+1][c]),
          .o_psum (w_ps[r][c+1])
        );
      end
    end
  endgenerate

  // Row result range check, then clamp or wrap to AW bits.
  logic [AW-1:0] w_res     [N];
  logic [N-1:0]  w_ovf;
  logic [IW-1:0] w_cap_idx [N];
  logic [N-1:0]  w_cap_en;

  generate
    for (genvar r = 0; r < N; r++) begin : g_out
      logic [ACCW-1:0] w_acc;
      logic [AW-1:0]   w_satv;
      logic [CW-1:0]   w_sub;
      assign w_acc = w_ps[r][N];
      if (SIGNED != 0) begin : g_s
        assign w_ovf[r] = !((&w_acc[ACCW-1:AW-1]) || (~|w_acc[ACCW-1:AW-1]));
        assign w_satv   = w_acc[ACCW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
      end else begin : g_u
        assign w_ovf[r] = |w_acc[ACCW-1:AW];
        assign w_satv   = '1;
      end
      assign w_res[r] = ((SAT != 0) && w_ovf[r]) ? w_satv : w_acc[AW-1:0];
      // Row r emits y[t] at compute cycle t+N+r.
      assign w_sub        = r_cnt - CW'(N + r);
      assign w_cap_en[r]  = (r_state == ST_COMPUTE) && (r_cnt >= CW'(N + r)) && (w_sub < CW'(r_xcnt));
      assign w_cap_idx[r] = w_sub[IW-1:0];
    end
  endgenerate

  // Each row writes its own lane of the output buffer at its own index.
  always_ff @(posedge CLK) begin
    for (int r = 0; r < N; r++) begin
      if (w_cap_en[r]) begin
        r_obuf[w_cap_idx[r]][r] <= w_res[r];
        r_oovf[w_cap_idx[r]][r] <= w_ovf[r];
      end
    end
  end

  assign out_data = out_valid ? r_obuf[r_rd] : '0;
  assign out_ovf  = out_valid ? r_oovf[r_rd] : '0;

endmodule

// File: tb/tb_systolic_matmul.sv
// Randomised scoreboard bench for systolic_matmul (N=4, DW=8, AW=16, signed, saturating).
module tb_systolic_matmul;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int AW   = 16;
  localparam int TMAX = 16;
  localparam longint AMAX = (longint'(1) << (AW - 1)) - 1;
  localparam longint AMIN = -AMAX - 1;

  typedef struct {
    logic [N*AW-1:0] d;
    logic [N-1:0]    o;
  } exp_t;

  logic            CLK = 1'b0;
  logic            RSTN = 1'b0;
  logic            w_valid = 1'b0, w_ready;
  logic [N*DW-1:0] w_data = '0;
  logic            in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic [N*DW-1:0] in_data = '0;
  logic            out_valid, out_ready = 1'b1;
  logic [N*AW-1:0] out_data;
  logic [N-1:0]    out_ovf;
  logic            busy;

  int n_cmp = 0;
  int n_bad = 0;
  int mw   [N][N];
  int wrow [N][N];
  exp_t q[$];
  logic [N*DW-1:0] xv[$];

  systolic_matmul #(.N(N), .DW(DW), .AW(AW), .TMAX(TMAX), .SIGNED(1), .SAT(1)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exhausted, want completion");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [N*DW-1:0] pk(input int a, input int b, input int c, input int d);
    logic [N*DW-1:0] v;
    v[0*DW +: DW] = DW'(a);
    v[1*DW +: DW] = DW'(b);
    v[2*DW +: DW] = DW'(c);
    v[3*DW +: DW] = DW'(d);
    return v;
  endfunction

  function automatic int rnd8();
    logic [7:0] b;
    b = 8'($urandom());
    return int'($signed(b));
  endfunction

  // Reference: y[r] = sum_c W[r][c]*x[c] in 64-bit, clamped to the AW signed range.
  function automatic void push_exp(input logic [N*DW-1:0] x);
    exp_t e;
    longint s;
    logic [DW-1:0] xs;
    e.d = '0;
    e.o = '0;
    for (int r = 0; r < N; r++) begin
      s = 0;
      for (int c = 0; c < N; c++) begin
        xs = x[c*DW +: DW];
        s += longint'(mw[r][c]) * longint'($signed(xs));
      end
      if (s > AMAX) begin
        s = AMAX;
        e.o[r] = 1'b1;
      end else if (s < AMIN) begin
        s = AMIN;
        e.o[r] = 1'b1;
      end
      e.d[r*AW +: AW] = AW'(s);
    end
    q.push_back(e);
  endfunction

  // Monitor: every cycle with out_valid is checked against the queue head.
  always @(negedge CLK) begin
    if (RSTN && out_valid) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: out_valid=1 with data %0h, want no output", out_data);
      end else begin
        chk("out_data", out_data, q[0].d);
        chk("out_ovf", out_ovf, q[0].o);
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_w();
    bit ok;
    for (int k = 0; k < N; k++) begin
      for (int c = 0; c < N; c++) w_data[c*DW +: DW] = DW'(wrow[k][c]);
      w_valid = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 100; n++) begin
        if (w_ready) begin
          ok = 1'b1;
          step();
          break;
        end
        step();
      end
      if (!ok) begin
        n_cmp++;
        n_bad++;
        $display("FAIL w_handshake: row %0d not accepted, want w_ready", k);
      end
    end
    w_valid = 1'b0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) mw[r][c] = wrow[r][c];
  endtask

  task automatic send(input int n, input bit last);
    bit ok;
    for (int i = 0; i < n; i++) begin
      in_data  = xv[i];
      in_last  = last && (i == n - 1);
      in_valid = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
        if (in_ready) begin
          ok = 1'b1;
          push_exp(xv[i]);
          step();
          break;
        end
        step();
      end
      if (!ok) begin
        n_cmp++;
        n_bad++;
        $display("FAIL in_handshake: vector %0d not accepted, want in_ready", i);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_empty(input string nm, input bit rnd);
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 2000) begin
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      step();
      n++;
    end
    out_ready = 1'b1;
    n_cmp++;
    if (n >= 2000) begin
      n_bad++;
      $display("FAIL %s: drain timeout, %0d results pending, want 0", nm, q.size());
    end
  endtask

  task automatic rand_w();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) wrow[r][c] = rnd8();
  endtask

  task automatic rand_x(input int n);
    xv.delete();
    for (int i = 0; i < n; i++) xv.push_back(pk(rnd8(), rnd8(), rnd8(), rnd8()));
  endtask

  initial begin
    int n;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) mw[r][c] = 0;

    // Reset state
    repeat (3) step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ovf", out_ovf, 0);
    RSTN = 1'b1;
    step();

    // Identity weights with first-result latency
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) wrow[r][c] = (r == c) ? 1 : 0;
    load_w();
    xv.delete();
    xv.push_back(pk(1, 2, 3, 4));
    send(1, 1);
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    chk("first_valid_latency", n, 2 * N);
    wait_empty("identity", 0);

    // Signed weights: row0 = {-1,2,-3,4}, x = {5,6,7,8} gives 18
    rand_w();
    wrow[0][0] = -1; wrow[0][1] = 2; wrow[0][2] = -3; wrow[0][3] = 4;
    load_w();
    xv.delete();
    xv.push_back(pk(5, 6, 7, 8));
    xv.push_back(pk(rnd8(), rnd8(), rnd8(), rnd8()));
    send(2, 1);
    wait_empty("signed", 0);

    // Saturation both directions
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) wrow[r][c] = 127;
    load_w();
    xv.delete();
    xv.push_back(pk(127, 127, 127, 127));
    xv.push_back(pk(-128, -128, -128, -128));
    xv.push_back(pk(1, -1, 2, -2));
    send(3, 1);
    wait_empty("saturation", 0);

    // Batch length cap: TMAX accepted, extras refused
    rand_w();
    load_w();
    rand_x(TMAX + 2);
    send(TMAX, 0);
    in_valid = 1'b1;
    in_data  = xv[TMAX];
    for (int i = 0; i < 3; i++) begin
      chk("in_ready_after_tmax", in_ready, 0);
      step();
    end
    in_data = xv[TMAX + 1];
    chk("in_ready_after_tmax", in_ready, 0);
    step();
    in_valid = 1'b0;
    wait_empty("batch_len", 1);

    // Backpressure mid-drain, then weight reuse via input-only start
    rand_x(4);
    send(4, 1);
    n = 0;
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
    chk("bp_reached_drain", out_valid, 1);
    step();
    out_ready = 1'b0;
    repeat (5) step();
    out_ready = 1'b1;
    wait_empty("backpressure", 0);

    // Random batches, some reusing weights, random out_ready
    for (int it = 0; it < 3; it++) begin
      if (it != 1) begin
        rand_w();
        load_w();
      end
      rand_x($urandom_range(1, TMAX));
      send(xv.size(), 1);
      wait_empty("random", 1);
    end

    // Reset during COMPUTE aborts the batch; W reads as zero afterwards
    rand_w();
    load_w();
    rand_x(6);
    send(6, 1);
    repeat (3) step();
    RSTN = 1'b0;
    q.delete();
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    repeat (2) step();
    RSTN = 1'b1;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) mw[r][c] = 0;
    repeat (6) step();
    chk("post_rst_busy", busy, 0);
    rand_x(2);
    send(2, 1);
    wait_empty("post_rst_zero_w", 0);
    rand_w();
    load_w();
    rand_x(3);
    send(3, 1);
    wait_empty("post_rst_clean", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
